// File: rtl/ni_pkg.sv
// ni_pkg: shared types, default parameters and ID/address helpers for the
// ni_gen2 network interface.
package ni_pkg;

    // Default build parameters for ni_gen2.
    localparam int unsigned DEF_GPU_ID      = 27;
    localparam int unsigned DEF_NUM_GPUS    = 32;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_HDR_W       = 6;
    localparam int unsigned DEF_ADDR_OFFSET = 3;
    localparam int unsigned DEF_FIFO_DEPTH  = 8;
    localparam int unsigned STAT_W          = 16;

    // A flit as seen on either side: header in the top HDR_W bits, payload below.
    typedef struct packed {
        logic [DEF_HDR_W-1:0]            hdr;
        logic [DEF_DATA_W-DEF_HDR_W-1:0] payload;
    } flit_t;

    // GPU ID to routing address.
    function automatic int unsigned id_to_addr(input int unsigned id,
                                               input int unsigned offset);
        return id + offset;
    endfunction

    // Routing address back to GPU ID.
    function automatic int unsigned addr_to_id(input int unsigned addr,
                                               input int unsigned offset);
        return addr - offset;
    endfunction

    // A destination is legal when it names an existing endpoint (IDs start at 1).
    function automatic logic id_legal(input int unsigned id,
                                      input int unsigned num_gpus);
        return (id >= 1) && (id <= num_gpus);
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// ni_fifo: show-ahead synchronous FIFO. The head entry always drives dout;
// push is ignored when full and pop is ignored when empty.
module ni_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer and occupancy values; pointers wrap at DEPTH by width.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; entries are only observable once written, and an unreset array maps onto plain RAM.
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ni_gen2.sv
// ni_gen2: GPU network interface. Translates destination GPU IDs into routing
// addresses on the way out, checks and strips addresses on the way in, and
// buffers each direction in an ni_fifo. Malformed/misrouted flits are dropped.
// Build option: define NI_STATS_EN to enable the saturating drop counters.
module ni_gen2 import ni_pkg::*; #(
    parameter int unsigned GPU_ID      = DEF_GPU_ID,
    parameter int unsigned NUM_GPUS    = DEF_NUM_GPUS,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned HDR_W       = DEF_HDR_W,
    parameter int unsigned ADDR_OFFSET = DEF_ADDR_OFFSET,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] gpu_data_in,
    input  logic              gpu_valid_in,
    output logic              gpu_ready_out,
    output logic [DATA_W-1:0] gpu_data_out,
    output logic              gpu_valid_out,
    input  logic              gpu_ready_in,
    output logic [DATA_W-1:0] router_data_out,
    output logic              router_valid_out,
    input  logic              router_ready_in,
    input  logic [DATA_W-1:0] router_data_in,
    input  logic              router_valid_in,
    output logic              router_ready_out,
    output logic [15:0]       bad_dest_cnt,
    output logic [15:0]       misroute_cnt
);

    localparam int unsigned PAY_W = DATA_W - HDR_W;
    localparam logic [HDR_W-1:0] MY_ADDR = HDR_W'(id_to_addr(GPU_ID, ADDR_OFFSET));

    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    // Reset asserts immediately and is released two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // GPU -> router: legal destinations are rewritten to routing addresses.
    logic [HDR_W-1:0]  gpu_dest;
    logic [PAY_W-1:0]  gpu_pay;
    logic              gpu_xfer, gpu_legal, g2r_push, g2r_pop, g2r_full, g2r_empty;
    logic [DATA_W-1:0] g2r_din;

    assign gpu_dest  = gpu_data_in[DATA_W-1 -: HDR_W];
    assign gpu_pay   = gpu_data_in[PAY_W-1:0];
    assign gpu_xfer  = gpu_valid_in && gpu_ready_out;
    assign gpu_legal = id_legal(32'(gpu_dest), NUM_GPUS);
    assign g2r_push  = gpu_xfer && gpu_legal;
    assign g2r_din   = {HDR_W'(id_to_addr(32'(gpu_dest), ADDR_OFFSET)), gpu_pay};
    assign gpu_ready_out    = !g2r_full;
    assign router_valid_out = !g2r_empty;
    assign g2r_pop          = router_valid_out && router_ready_in;

    ni_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_g2r (
        .clk     (clk),
        .reset_n (rst_n_int),
        .push    (g2r_push),
        .pop     (g2r_pop),
        .din     (g2r_din),
        .dout    (router_data_out),
        .full    (g2r_full),
        .empty   (g2r_empty),
        .count   ()
    );

    // Router -> GPU: only flits addressed to this endpoint are kept.
    logic [HDR_W-1:0]  rtr_hdr;
    logic [PAY_W-1:0]  rtr_pay;
    logic              rtr_xfer, rtr_match, r2g_push, r2g_pop, r2g_full, r2g_empty;
    logic [DATA_W-1:0] r2g_din;

    assign rtr_hdr   = router_data_in[DATA_W-1 -: HDR_W];
    assign rtr_pay   = router_data_in[PAY_W-1:0];
    assign rtr_xfer  = router_valid_in && router_ready_out;
    assign rtr_match = (rtr_hdr == MY_ADDR);
    assign r2g_push  = rtr_xfer && rtr_match;
    assign r2g_din   = {HDR_W'(addr_to_id(32'(rtr_hdr), ADDR_OFFSET)), rtr_pay};
    assign router_ready_out = !r2g_full;
    assign gpu_valid_out    = !r2g_empty;
    assign r2g_pop          = gpu_valid_out && gpu_ready_in;

    ni_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_r2g (
        .clk     (clk),
        .reset_n (rst_n_int),
        .push    (r2g_push),
        .pop     (r2g_pop),
        .din     (r2g_din),
        .dout    (gpu_data_out),
        .full    (r2g_full),
        .empty   (r2g_empty),
        .count   ()
    );

`ifdef NI_STATS_EN
    logic [STAT_W-1:0] bad_q, bad_d, mis_q, mis_d;

    // Saturating drop counters.
    always_comb begin
        bad_d = bad_q;
        mis_d = mis_q;
        if (gpu_xfer && !gpu_legal && (bad_q != '1)) bad_d = bad_q + STAT_W'(1);
        if (rtr_xfer && !rtr_match && (mis_q != '1)) mis_d = mis_q + STAT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            bad_q <= '0;
            mis_q <= '0;
        end else begin
            bad_q <= bad_d;
            mis_q <= mis_d;
        end
    end

    assign bad_dest_cnt = bad_q;
    assign misroute_cnt = mis_q;
`else
    assign bad_dest_cnt = '0;
    assign misroute_cnt = '0;
`endif

endmodule

// File: tb/tb_ni_gen2.sv
// tb_ni_gen2: directed bench for ni_gen2 with a queue-based reference model
// and a per-cycle compare process, plus literal expectations.
module tb_ni_gen2;
    import ni_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] gpu_data_in, gpu_data_out, router_data_out, router_data_in;
    logic        gpu_valid_in, gpu_ready_out, gpu_valid_out, gpu_ready_in;
    logic        router_valid_out, router_ready_in, router_valid_in, router_ready_out;
    logic [15:0] bad_dest_cnt, misroute_cnt;

    always #5 clk = ~clk;

    ni_gen2 dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .gpu_data_in      (gpu_data_in),
        .gpu_valid_in     (gpu_valid_in),
        .gpu_ready_out    (gpu_ready_out),
        .gpu_data_out     (gpu_data_out),
        .gpu_valid_out    (gpu_valid_out),
        .gpu_ready_in     (gpu_ready_in),
        .router_data_out  (router_data_out),
        .router_valid_out (router_valid_out),
        .router_ready_in  (router_ready_in),
        .router_data_in   (router_data_in),
        .router_valid_in  (router_valid_in),
        .router_ready_out (router_ready_out),
        .bad_dest_cnt     (bad_dest_cnt),
        .misroute_cnt     (misroute_cnt)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    localparam int DEPTH = 8;
    logic [15:0] g2r_m[$];
    logic [15:0] r2g_m[$];
    int unsigned bad_m, mis_m;
    bit          cmp_en = 0;
    bit          m_gacc, m_gpop, m_racc, m_rpop;

    // GPU flit -> router flit: header dest becomes dest+3, payload kept.
    function automatic bit gpu_legal_m(input logic [15:0] w);
        int d = int'(w[15:10]);
        return d >= 1 && d <= 32;
    endfunction
    function automatic logic [15:0] gpu_xform(input logic [15:0] w);
        int d = int'(w[15:10]);
        return 16'((((d + 3) % 64) * 1024) + int'(w[9:0]));
    endfunction
    function automatic logic [15:0] rtr_xform(input logic [15:0] w);
        int h = int'(w[15:10]);
        return 16'((((h - 3) % 64) * 1024) + int'(w[9:0]));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g2r_m.delete();
            r2g_m.delete();
            bad_m = 0;
            mis_m = 0;
        end else begin
            m_gacc = gpu_valid_in && (g2r_m.size() < DEPTH);
            m_gpop = router_ready_in && (g2r_m.size() > 0);
            m_racc = router_valid_in && (r2g_m.size() < DEPTH);
            m_rpop = gpu_ready_in && (r2g_m.size() > 0);
            if (m_gpop) void'(g2r_m.pop_front());
            if (m_rpop) void'(r2g_m.pop_front());
            if (m_gacc) begin
                if (gpu_legal_m(gpu_data_in)) g2r_m.push_back(gpu_xform(gpu_data_in));
                else if (bad_m < 65535) bad_m++;
            end
            if (m_racc) begin
                if (int'(router_data_in[15:10]) == 30) r2g_m.push_back(rtr_xform(router_data_in));
                else if (mis_m < 65535) mis_m++;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("router_valid_out", {31'b0, router_valid_out}, {31'b0, g2r_m.size() != 0});
            if (g2r_m.size() != 0) check("router_data_out", {16'b0, router_data_out}, {16'b0, g2r_m[0]});
            check("gpu_valid_out", {31'b0, gpu_valid_out}, {31'b0, r2g_m.size() != 0});
            if (r2g_m.size() != 0) check("gpu_data_out", {16'b0, gpu_data_out}, {16'b0, r2g_m[0]});
            check("gpu_ready_out", {31'b0, gpu_ready_out}, {31'b0, g2r_m.size() < DEPTH});
            check("router_ready_out", {31'b0, router_ready_out}, {31'b0, r2g_m.size() < DEPTH});
`ifdef NI_STATS_EN
            check("bad_dest_cnt", {16'b0, bad_dest_cnt}, bad_m);
            check("misroute_cnt", {16'b0, misroute_cnt}, mis_m);
`else
            check("bad_dest_cnt", {16'b0, bad_dest_cnt}, 32'd0);
            check("misroute_cnt", {16'b0, misroute_cnt}, 32'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_gpu(input logic [15:0] w);
        int   n = 0;
        logic acc;
        gpu_data_in  = w;
        gpu_valid_in = 1'b1;
        do begin
            @(negedge clk);
            acc = gpu_ready_out;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check("gpu_send_timeout", {31'b0, acc}, 32'd1);
        gpu_valid_in = 1'b0;
    endtask

    task automatic send_rtr(input logic [15:0] w);
        int   n = 0;
        logic acc;
        router_data_in  = w;
        router_valid_in = 1'b1;
        do begin
            @(negedge clk);
            acc = router_ready_out;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check("rtr_send_timeout", {31'b0, acc}, 32'd1);
        router_valid_in = 1'b0;
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        gpu_data_in = '0; gpu_valid_in = 0; gpu_ready_in = 0;
        router_data_in = '0; router_valid_in = 0; router_ready_in = 0;
        cycle(2);

        // Reset state.
        check("rst_router_valid", {31'b0, router_valid_out}, 32'd0);
        check("rst_gpu_valid",    {31'b0, gpu_valid_out},    32'd0);
        check("rst_gpu_ready",    {31'b0, gpu_ready_out},    32'd1);
        check("rst_router_ready", {31'b0, router_ready_out}, 32'd1);
        check("rst_bad_cnt",      {16'b0, bad_dest_cnt},     32'd0);
        check("rst_mis_cnt",      {16'b0, misroute_cnt},     32'd0);
        cmp_en  = 1;
        reset_n = 1'b1;
        cycle(3);

        // Legal GPU flit: dest 27 -> address 30.
        send_gpu(16'h6C05);
        check("g2r_first_valid", {31'b0, router_valid_out}, 32'd1);
        check("g2r_first_data",  {16'b0, router_data_out},  32'h7805);
        router_ready_in = 1; cycle(1); router_ready_in = 0;
        check("g2r_drained", {31'b0, router_valid_out}, 32'd0);

        // Router flits: one addressed here, one misrouted.
        send_rtr(16'h7805);
        check("r2g_data",  {16'b0, gpu_data_out},  32'h6C05);
        send_rtr(16'h7C05);
`ifdef NI_STATS_EN
        check("misroute_lit", {16'b0, misroute_cnt}, 32'd1);
`else
        check("misroute_lit", {16'b0, misroute_cnt}, 32'd0);
`endif
        gpu_ready_in = 1; cycle(1); gpu_ready_in = 0;
        check("r2g_only_one", {31'b0, gpu_valid_out}, 32'd0);

        // Illegal destinations 0 and 33.
        send_gpu(16'h0005);
        send_gpu(16'h8400);
        cycle(1);
        check("bad_no_output", {31'b0, router_valid_out}, 32'd0);
`ifdef NI_STATS_EN
        check("bad_dest_lit", {16'b0, bad_dest_cnt}, 32'd2);
`else
        check("bad_dest_lit", {16'b0, bad_dest_cnt}, 32'd0);
`endif

        // Fill g2r with router stalled, then drain while a 9th flit waits.
        for (int i = 1; i <= 8; i++) send_gpu(16'h1400 | 16'(i));
        check("full_ready_low", {31'b0, gpu_ready_out}, 32'd0);
        gpu_data_in = 16'h1409; gpu_valid_in = 1;
        cycle(1);
        check("full_still_low", {31'b0, gpu_ready_out}, 32'd0);
        check("full_head",      {16'b0, router_data_out}, 32'h2001);
        router_ready_in = 1;
        cycle(1);
        check("full_pop_push_refused", {31'b0, gpu_ready_out}, 32'd1);
        check("full_next_head",        {16'b0, router_data_out}, 32'h2002);
        cycle(1);
        gpu_valid_in = 0;
        cycle(10);
        check("full_drained", {31'b0, router_valid_out}, 32'd0);

        // Half full with simultaneous push and pop.
        router_ready_in = 0;
        for (int i = 1; i <= 4; i++) send_gpu(16'h0400 | 16'(i));
        gpu_data_in = 16'h0405; gpu_valid_in = 1; router_ready_in = 1;
        cycle(1);
        gpu_valid_in = 0; router_ready_in = 0;
        check("half_head", {16'b0, router_data_out}, 32'h1002);
        router_ready_in = 1;
        cycle(3);
        check("half_three_left", {31'b0, router_valid_out}, 32'd1);
        cycle(1);
        check("half_empty", {31'b0, router_valid_out}, 32'd0);

        // Wrap-around: 20 flits through both FIFOs at once.
        gpu_ready_in = 1;
        fork
            for (int i = 0; i < 20; i++)
                send_gpu(16'((((i % 32) + 1) * 1024) + ((i * 37) % 1024)));
            for (int j = 0; j < 20; j++)
                send_rtr(16'((30 * 1024) + ((j * 53) % 1024)));
        join
        cycle(4);
        check("wrap_g2r_empty", {31'b0, router_valid_out}, 32'd0);
        check("wrap_r2g_empty", {31'b0, gpu_valid_out},    32'd0);

        // Reset mid-burst with 5 flits queued each way.
        router_ready_in = 0; gpu_ready_in = 0;
        for (int i = 1; i <= 5; i++) send_gpu(16'h0800 | 16'(i));
        for (int i = 1; i <= 5; i++) send_rtr(16'h7800 | 16'(i));
        send_rtr(16'h0001);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_router_valid", {31'b0, router_valid_out}, 32'd0);
        check("mid_rst_gpu_valid",    {31'b0, gpu_valid_out},    32'd0);
        check("mid_rst_gpu_ready",    {31'b0, gpu_ready_out},    32'd1);
        check("mid_rst_router_ready", {31'b0, router_ready_out}, 32'd1);
        check("mid_rst_bad_cnt",      {16'b0, bad_dest_cnt},     32'd0);
        check("mid_rst_mis_cnt",      {16'b0, misroute_cnt},     32'd0);
        cycle(1);
        reset_n = 1'b1;
        cycle(3);
        send_gpu(16'h6C05);
        check("post_rst_data", {16'b0, router_data_out}, 32'h7805);
        router_ready_in = 1;
        cycle(2);

        cmp_en = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
